uart_frame_rx_ctrl: RTL

- Sequences the byte stream from the UART receiver (one-cycle `rx_en` strobe plus data byte) into verified frames.
- Frame format: SYNC, LEN, LEN payload bytes, CSUM.
- Hunts for SYNC, buffers the payload, checks length, checksum and inter-byte timeout, then releases the payload downstream as a valid/ready byte stream with a last flag.
- Sits directly between the UART receiver and the command decoder.

---
 rtl/uart_frame_rx_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_frame_rx_ctrl
//
// Turns the byte strobes coming out of the UART receiver into verified frames
// of the form SYNC, LEN, LEN payload bytes, CSUM. The payload is buffered while
// it arrives, then released to the command decoder as a valid/ready byte
// stream with a last flag once length and checksum have been confirmed.
//
// Ports:
//   i_clk          single clock, everything on the rising edge
//   i_rst          synchronous active-high reset
//   i_rx_data      received byte, qualified by i_rx_en
//   i_rx_en        one-cycle strobe per received byte
//   o_data         payload byte being offered downstream
//   o_valid        o_data is valid (only while delivering)
//   o_last         o_data is the final payload byte of the frame
//   i_ready        downstream accepts o_data this cycle
//   o_len          length of the frame being delivered
//   o_busy         controller is anywhere but idle
//   o_err_len      one-cycle pulse, LEN byte out of range
//   o_err_csum     one-cycle pulse, checksum mismatch
//   o_err_timeout  one-cycle pulse, receiver went quiet mid-frame
//   o_overrun      one-cycle pulse, a byte was dropped while delivering
// -----------------------------------------------------------------------------
module uart_frame_rx_ctrl #(
   parameter int         CLOCK_FREQUENCY = 1_000_000,
   parameter int         BAUD_RATE       = 12_000,
   parameter int         TIMEOUT_BAUDS   = 20,
   parameter int         MAX_PAYLOAD     = 16,
   parameter logic [7:0] SYNC_BYTE       = 8'hA5,
   localparam int        LEN_W           = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_en,
   output logic [7:0]       o_data,
   output logic             o_valid,
   output logic             o_last,
   input  logic             i_ready,
   output logic [LEN_W-1:0] o_len,
   output logic             o_busy,
   output logic             o_err_len,
   output logic             o_err_csum,
   output logic             o_err_timeout,
   output logic             o_overrun
);

   localparam int CLOCKS_PER_BAUD = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int TIMEOUT_CYCLES  = CLOCKS_PER_BAUD * TIMEOUT_BAUDS;
   localparam int TO_W            = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PTR_W           = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_DELIVER
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [7:0]        payload_mem [MAX_PAYLOAD];
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  len_m1;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [7:0]        csum;
   logic [TO_W-1:0]   timeout_cnt;
   logic              len_ok;
   logic              wr_last;
   logic              rd_last;
   logic              expired;
   logic              err_len_next;
   logic              err_csum_next;
   logic              err_timeout_next;
   logic              overrun_next;

   assign len_ok  = (i_rx_data != 8'h00) && (i_rx_data <= 8'(MAX_PAYLOAD));
   assign len_m1  = len - LEN_W'(1);
   assign wr_last = (LEN_W'(wr_ptr) == len_m1);
   assign rd_last = (LEN_W'(rd_ptr) == len_m1);
   // A strobe in the cycle the counter sits at zero takes priority over expiry.
   assign expired = (timeout_cnt == '0) && !i_rx_en;

   assign o_valid = (state == ST_DELIVER);
   assign o_data  = o_valid ? payload_mem[rd_ptr] : 8'h00;
   assign o_last  = o_valid && rd_last;
   assign o_len   = len;
   assign o_busy  = (state != ST_IDLE);

   // Next-state decode plus the error/overrun pulses, which are registered so
   // they appear the cycle after the offending strobe or expiry.
   always_comb begin
      state_next       = state;
      err_len_next     = 1'b0;
      err_csum_next    = 1'b0;
      err_timeout_next = 1'b0;
      overrun_next     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_rx_en && (i_rx_data == SYNC_BYTE)) state_next = ST_LEN;
         end
         ST_LEN: begin
            if (i_rx_en) begin
               if (len_ok) begin
                  state_next = ST_PAYLOAD;
               end else begin
                  state_next   = ST_IDLE;
                  err_len_next = 1'b1;
               end
            end else if (expired) begin
               state_next       = ST_IDLE;
               err_timeout_next = 1'b1;
            end
         end
         ST_PAYLOAD: begin
            if (i_rx_en) begin
               if (wr_last) state_next = ST_CSUM;
            end else if (expired) begin
               state_next       = ST_IDLE;
               err_timeout_next = 1'b1;
            end
         end
         ST_CSUM: begin
            if (i_rx_en) begin
               if (i_rx_data == csum) begin
                  state_next = ST_DELIVER;
               end else begin
                  state_next    = ST_IDLE;
                  err_csum_next = 1'b1;
               end
            end else if (expired) begin
               state_next       = ST_IDLE;
               err_timeout_next = 1'b1;
            end
         end
         ST_DELIVER: begin
            if (i_rx_en) overrun_next = 1'b1;
            if (i_ready && rd_last) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register and frame bookkeeping: length, running checksum, write and
   // read pointers and the inter-byte timeout counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         len           <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         csum          <= 8'h00;
         timeout_cnt   <= '0;
         o_err_len     <= 1'b0;
         o_err_csum    <= 1'b0;
         o_err_timeout <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         state         <= state_next;
         o_err_len     <= err_len_next;
         o_err_csum    <= err_csum_next;
         o_err_timeout <= err_timeout_next;
         o_overrun     <= overrun_next;
         case (state)
            ST_IDLE: begin
               if (i_rx_en && (i_rx_data == SYNC_BYTE)) timeout_cnt <= TO_RELOAD;
            end
            ST_LEN, ST_PAYLOAD, ST_CSUM: begin
               if (i_rx_en) begin
                  timeout_cnt <= TO_RELOAD;
               end else if (timeout_cnt != '0) begin
                  timeout_cnt <= timeout_cnt - TO_W'(1);
               end
               if (i_rx_en && (state == ST_LEN) && len_ok) begin
                  len    <= LEN_W'(i_rx_data);
                  csum   <= i_rx_data;
                  wr_ptr <= '0;
               end
               if (i_rx_en && (state == ST_PAYLOAD)) begin
                  csum   <= csum ^ i_rx_data;
                  wr_ptr <= wr_ptr + PTR_W'(1);
               end
               if (i_rx_en && (state == ST_CSUM)) rd_ptr <= '0;
            end
            ST_DELIVER: begin
               if (i_ready) begin
                  if (rd_last) begin
                     rd_ptr <= '0;
                     wr_ptr <= '0;
                  end else begin
                     rd_ptr <= rd_ptr + PTR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Payload storage has no reset: it is only ever read after being rewritten
   // by the frame that is being delivered.
   always_ff @(posedge i_clk) begin
      if (!i_rst && (state == ST_PAYLOAD) && i_rx_en) payload_mem[wr_ptr] <= i_rx_data;
   end

endmodule
